// File: rtl/i2c_master_byte_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_master_byte_ctrl
//
// Single-master I2C controller that runs one complete single-byte transaction
// toward a 7-bit-addressed slave:
//   START, address + R/W, slave ACK, one data byte, ACK (write) or master
//   NACK (read), STOP.
// The block sits between a processor's command/status registers and the
// open-drain SCL/SDA pads. It never drives a pad high. It only asserts a
// pull-low enable per line, and the pad logic turns that into the open drain.
//
// Bit timing: every bit period is four quarters q0..q3, each CLK_DIV clocks
// long. SCL is pulled low in q0/q1 and released in q2/q3. SDA moves only on
// entry to q0, except for the START and STOP edges. The slave's SDA level is
// sampled on the q2->q3 quarter tick.
//
// Parameters:
//   CLK_DIV   system clocks per quarter SCL period (legal range 2..4095)
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     one-clock command strobe, honoured only while idle
//   slv_addr  7-bit slave address, latched on an accepted start
//   rw        0 = write, 1 = read, latched on an accepted start
//   wdata     write byte, latched on an accepted start
//   sda_i     synchronised SDA pad level
//   scl_oe    1 = pull SCL low, 0 = release
//   sda_oe    1 = pull SDA low, 0 = release
//   busy      high from the accepted start until done
//   done      one-clock pulse when the transaction ends
//   ack_err   slave NACKed the address or the write byte; cleared by next start
//   rdata     byte received by the last completed read
// -----------------------------------------------------------------------------
module i2c_master_byte_ctrl #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] slv_addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int unsigned     DIV_W    = 12;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_DACK,
    S_RDATA,
    S_MNACK,
    S_STOP
  } state_e;

  state_e           state_q,   state_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [1:0]       qtr_q,     qtr_d;
  logic [2:0]       bit_q,     bit_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       wdata_q,   wdata_d;
  logic             rw_q,      rw_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             ack_err_q, ack_err_d;
  logic [7:0]       rdata_q,   rdata_d;
  logic             scl_oe_q,  scl_oe_d;
  logic             sda_oe_q,  sda_oe_d;

  logic qtick;    // last clock of the current quarter
  logic sample;   // q2 -> q3 boundary: slave data is valid, SCL is high
  logic bit_end;  // q3 -> q0 boundary: the bit period is over

  assign qtick   = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign sample  = qtick && (qtr_q == 2'd2);
  assign bit_end = qtick && (qtr_q == 2'd3);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block first gets a hold/idle default.
  // That way no path through the case leaves a value unassigned and turns it
  // into a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;

    // The quarter timebase is frozen at zero while idle. Every transaction
    // therefore starts on a clean quarter boundary.
    if (state_q != S_IDLE) begin
      div_d = qtick ? '0 : div_q + DIV_W'(1);
      if (qtick) begin
        qtr_d = qtr_q + 2'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = {slv_addr, rw};
          wdata_d   = wdata;
          rw_d      = rw;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR, S_WDATA: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
          end
        end
      end

      S_AACK: begin
        if (sample && sda_i) begin
          ack_err_d = 1'b1;
        end
        // ack_err_q already holds this bit's sample, because the sample
        // boundary comes one quarter before bit_end.
        if (bit_end) begin
          if (ack_err_q) begin
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_RDATA;
          end else begin
            shift_d = wdata_q;
            state_d = S_WDATA;
          end
        end
      end

      S_DACK: begin
        if (sample && sda_i) begin
          ack_err_d = 1'b1;
        end
        if (bit_end) begin
          state_d = S_STOP;
        end
      end

      S_RDATA: begin
        if (sample) begin
          shift_d = {shift_q[6:0], sda_i};
        end
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rdata_d = shift_q;
            state_d = S_MNACK;
          end
        end
      end

      S_MNACK: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pad enables
  // ---------------------------------------------------------------------------
  // The pad enables are decoded from the next state and then registered, so
  // the pads see glitch-free flop outputs. The current-state decode would give
  // the same waveform one flop stage later. Here the enable flops track the
  // state flops exactly.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    unique case (state_d)
      S_START: begin
        sda_oe_d = qtr_d[1];             // SDA falls while SCL is high: START
      end
      S_ADDR, S_WDATA: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ~shift_d[7];
      end
      S_AACK, S_DACK, S_RDATA, S_MNACK: begin
        scl_oe_d = ~qtr_d[1];            // SDA left to the slave, or NACK
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = ~qtr_d[1];            // SDA rises while SCL is high: STOP
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop sits
  // on the async reset, so reset releases both pads at once without waiting
  // for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_byte_ctrl
//
// Bench for i2c_master_byte_ctrl (CLK_DIV = 4). It contains a behavioural
// 8-bit IO extender slave at address 0x27 and a bus monitor. The monitor
// counts START/STOP conditions and SCL pulses, and it checks the SCL high and
// low times. A table of transactions holds the expected results for each
// entry; a hand-written sequence covers reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_i2c_master_byte_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [6:0] slv_addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sda_i;
  logic       scl_oe, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;

  // Open-drain bus: a line is low if anyone pulls it.
  logic sl_pull = 1'b0;
  logic scl_bus, sda_bus;
  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | sl_pull);
  assign sda_i   = sda_bus;

  i2c_master_byte_ctrl #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .slv_addr (slv_addr),
    .rw       (rw),
    .wdata    (wdata),
    .sda_i    (sda_i),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model + bus monitor (sampled on the falling clock edge)
  // ---------------------------------------------------------------------------
  typedef enum {SL_IDLE, SL_ADDR, SL_ACK_A, SL_WR, SL_ACK_W, SL_RD, SL_RACK} sl_e;

  sl_e        sl_state     = SL_IDLE;
  int         sl_cnt       = 0;
  logic [7:0] sl_sh        = 8'h00;
  logic [7:0] sl_io        = 8'h00;
  logic [7:0] sl_addr_seen = 8'h00;
  logic       sl_rw        = 1'b0;
  logic       sl_nack      = 1'b0;

  int cnt_start = 0, cnt_stop = 0, cnt_done = 0, cnt_busy = 0;
  int cnt_rise  = 0, cnt_short = 0;

  logic scl_p = 1'b1, sda_p = 1'b1, scl_n, sda_n;
  int   run_len  = 0;
  logic hi_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      scl_n = scl_bus;
      sda_n = sda_bus;
      if (busy) cnt_busy++;
      if (done) cnt_done++;

      if (scl_p && scl_n && sda_p && !sda_n) begin
        cnt_start++;
        sl_state = SL_ADDR;
        sl_cnt   = 0;
        sl_pull  = 1'b0;
        sl_nack  = 1'b0;
      end else if (scl_p && scl_n && !sda_p && sda_n) begin
        cnt_stop++;
        sl_state = SL_IDLE;
        sl_pull  = 1'b0;
      end else if (!scl_p && scl_n) begin
        case (sl_state)
          SL_ADDR, SL_WR: begin sl_sh = {sl_sh[6:0], sda_n}; sl_cnt++; end
          SL_RD:          begin sl_sh = {sl_sh[6:0], 1'b0};  sl_cnt++; end
          SL_RACK:        sl_nack = sda_n;
          default: ;
        endcase
      end else if (scl_p && !scl_n) begin
        case (sl_state)
          SL_ADDR: if (sl_cnt == 8) begin
            sl_addr_seen = sl_sh;
            if (sl_sh[7:1] == 7'h27) begin
              sl_pull  = 1'b1;
              sl_rw    = sl_sh[0];
              sl_state = SL_ACK_A;
            end else begin
              sl_state = SL_IDLE;
            end
          end
          SL_ACK_A: begin
            sl_cnt = 0;
            if (sl_rw) begin
              sl_sh    = sl_io;
              sl_pull  = ~sl_io[7];
              sl_state = SL_RD;
            end else begin
              sl_pull  = 1'b0;
              sl_state = SL_WR;
            end
          end
          SL_WR: if (sl_cnt == 8) begin
            sl_io    = sl_sh;
            sl_pull  = 1'b1;
            sl_state = SL_ACK_W;
          end
          SL_ACK_W: begin sl_pull = 1'b0; sl_state = SL_IDLE; end
          SL_RD: begin
            if (sl_cnt == 8) begin
              sl_pull  = 1'b0;
              sl_state = SL_RACK;
            end else begin
              sl_pull = ~sl_sh[7];
            end
          end
          SL_RACK: sl_state = SL_IDLE;
          default: ;
        endcase
      end

      // SCL timing: a low phase must be 2*DIV, except the single DIV-long low
      // that opens STOP. A high phase is checked only between two falls of
      // the same transaction.
      if (scl_n != scl_p) begin
        if (!scl_p && busy) begin
          check("scl_low_time", (run_len == DIV) || (run_len == 2*DIV), 1);
          if (run_len == DIV) cnt_short++;
          cnt_rise++;
        end
        if (scl_p && hi_valid) check("scl_high_time", run_len, 2*DIV);
        hi_valid = !scl_p && busy;
        run_len  = 1;
      end else begin
        run_len++;
      end
      if (!busy) hi_valid = 1'b0;
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    int         dup_at;       // clocks after accept for a second start, -1 none
    logic       exp_ack_err;
    logic [7:0] exp_rdata;
    logic [7:0] exp_io;
    int         exp_busy;
    int         exp_rises;
  } vec_t;

  task automatic do_txn(input vec_t v, input string tag);
    int d_start, d_stop, d_done, d_busy, d_rise, d_short, waited;
    d_start = cnt_start; d_stop = cnt_stop; d_done = cnt_done;
    d_busy  = cnt_busy;  d_rise = cnt_rise; d_short = cnt_short;
    @(negedge clk);
    slv_addr = v.addr; rw = v.rw; wdata = v.wdata; start = 1'b1;
    waited = 0;
    while (cnt_done == d_done && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (waited == v.dup_at) begin
        slv_addr = 7'h10; rw = 1'b1; wdata = 8'h00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " done_in_time"}, waited < 2000, 1);
    repeat (4) @(negedge clk);
    check({tag, " done_pulses"}, cnt_done - d_done, 1);
    check({tag, " busy_clocks"}, cnt_busy - d_busy, v.exp_busy);
    check({tag, " busy_low"},    busy, 0);
    check({tag, " ack_err"},     ack_err, v.exp_ack_err);
    check({tag, " rdata"},       rdata, v.exp_rdata);
    check({tag, " slave_io"},    sl_io, v.exp_io);
    check({tag, " bus_addr"},    sl_addr_seen, {v.addr, v.rw});
    check({tag, " starts"},      cnt_start - d_start, 1);
    check({tag, " stops"},       cnt_stop - d_stop, 1);
    check({tag, " scl_pulses"},  cnt_rise - d_rise, v.exp_rises);
    check({tag, " stop_low"},    cnt_short - d_short, 1);
    if (v.rw && !v.exp_ack_err) check({tag, " master_nack"}, sl_nack, 1);
  endtask

  vec_t vecs[11];
  vec_t hv;

  initial begin
    //            addr   rw    wdata  dup ae    rdata  io     busy rises
    vecs[0]  = '{7'h27, 1'b0, 8'hA5, -1, 1'b0, 8'h00, 8'hA5, 320, 19};
    vecs[1]  = '{7'h27, 1'b1, 8'h00, -1, 1'b0, 8'hA5, 8'hA5, 320, 19};
    vecs[2]  = '{7'h28, 1'b0, 8'h3C, -1, 1'b1, 8'hA5, 8'hA5, 176, 10};
    vecs[3]  = '{7'h27, 1'b0, 8'h3C, -1, 1'b0, 8'hA5, 8'h3C, 320, 19};
    vecs[4]  = '{7'h27, 1'b1, 8'hFF, -1, 1'b0, 8'h3C, 8'h3C, 320, 19};
    vecs[5]  = '{7'h28, 1'b1, 8'h00, -1, 1'b1, 8'h3C, 8'h3C, 176, 10};
    vecs[6]  = '{7'h27, 1'b0, 8'h00, -1, 1'b0, 8'h3C, 8'h00, 320, 19};
    vecs[7]  = '{7'h27, 1'b1, 8'h00, -1, 1'b0, 8'h00, 8'h00, 320, 19};
    vecs[8]  = '{7'h27, 1'b0, 8'h81, -1, 1'b0, 8'h00, 8'h81, 320, 19};
    vecs[9]  = '{7'h27, 1'b1, 8'h00, -1, 1'b0, 8'h81, 8'h81, 320, 19};
    vecs[10] = '{7'h27, 1'b0, 8'h66, 50, 1'b0, 8'h81, 8'h66, 320, 19};

    reset_n = 1'b0; start = 1'b0; slv_addr = '0; rw = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset scl_oe",  scl_oe, 0);
    check("reset sda_oe",  sda_oe, 0);
    check("reset busy",    busy, 0);
    check("reset done",    done, 0);
    check("reset ack_err", ack_err, 0);
    check("reset rdata",   rdata, 8'h00);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Reset during WDATA bit 3 of a write of 0xC3 (bit 3 = 0, so SDA is low).
    @(negedge clk);
    slv_addr = 7'h27; rw = 1'b0; wdata = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (211) @(negedge clk);
    check("midrst busy_before",   busy, 1);
    check("midrst scl_before",    scl_oe, 1);
    check("midrst sda_before",    sda_oe, 1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst scl_oe_async",  scl_oe, 0);
    check("midrst sda_oe_async",  sda_oe, 0);
    check("midrst busy_async",    busy, 0);
    repeat (3) @(negedge clk);
    check("midrst rdata_cleared", rdata, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst io_kept",       sl_io, 8'h66);

    hv = '{7'h27, 1'b0, 8'h5A, -1, 1'b0, 8'h00, 8'h5A, 320, 19};
    do_txn(hv, "post_rst_wr");
    hv = '{7'h27, 1'b1, 8'h00, -1, 1'b0, 8'h5A, 8'h5A, 320, 19};
    do_txn(hv, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
